clk_en_gen: RTL

Parametrised, lock-qualified clock-enable generator sitting directly downstream of the FPGA clock generator. It runs on the single system clock and gates startup on a stable PLL lock. It then produces N independent one-cycle enable strobes at programmable divide ratios, plus a synchronous reset for downstream logic. It replaces ad-hoc per-peripheral dividers and handles divider updates without glitches, multi-channel phase realignment and lock-loss recovery.

---
 rtl/clk_en_gen_pkg.sv | 19 +
 rtl/clk_en_gen_chan.sv | 81 ++++++++
 rtl/prim_flop_2sync.sv | 37 +++
 rtl/clk_en_gen.sv | 135 +++++++++++++
 4 files changed

// File: rtl/clk_en_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_gen_pkg
// Shared types and constants for the lock-qualified clock-enable generator.
//   state_e      : lock FSM states (WAIT_LOCK, STABILISE, RUN)
//   LossCntWidth : width of the lock-loss counter
//   LossCntMax   : saturation value of the lock-loss counter
// -----------------------------------------------------------------------------
package clk_en_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int                      LossCntWidth = 8;
    localparam logic [LossCntWidth-1:0] LossCntMax   = 8'hFF;

endpackage

// File: rtl/clk_en_gen_chan.sv
// -----------------------------------------------------------------------------
// clk_en_gen_chan
// One enable channel: period counter, active and pending divide values, and
// the strobe decode.
// Ports:
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   run_i    : generator is in RUN (registered)
//   sync_i   : realign counter to zero (already qualified with RUN)
//   div_we_i : write strobe for div_i
//   div_i    : new divide value (strobe period = div + 1)
//   clk_en_o : one-cycle enable strobe
// -----------------------------------------------------------------------------
module clk_en_gen_chan #(
    parameter int DivWidth   = 16,
    parameter int DefaultDiv = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic                sync_i,
    input  logic                div_we_i,
    input  logic [DivWidth-1:0] div_i,
    output logic                clk_en_o
);

    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic [DivWidth-1:0] div_act_q, div_act_d;
    logic [DivWidth-1:0] div_pend_q, div_pend_d;
    logic                pend_q, pend_d;

    logic                wrap;
    logic                apply;
    logic [DivWidth-1:0] div_next;

    // Strobe is a decode of registers only, so it is glitch-free downstream.
    assign wrap     = run_i && (cnt_q == div_act_q);
    assign clk_en_o = wrap;

    // A new divide may only take effect at a period boundary (wrap or sync).
    // Outside RUN the counter is parked at zero, so there is no period to
    // protect and writes land at once.
    assign apply    = !run_i || wrap || sync_i;
    // A write in the applying cycle wins over an older pending value.
    assign div_next = div_we_i ? div_i : (pend_q ? div_pend_q : div_act_q);

    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        if (apply) begin
            cnt_d     = '0;
            div_act_d = div_next;
            pend_d    = 1'b0;
        end else begin
            cnt_d = cnt_q + DivWidth'(1);
            if (div_we_i) begin
                div_pend_d = div_i;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            div_act_q  <= DivWidth'(DefaultDiv);
            div_pend_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: rtl/prim_flop_2sync.sv
// -----------------------------------------------------------------------------
// prim_flop_2sync
// Two-flop synchroniser for bringing an asynchronous level into clk_i.
// Ports:
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset, both stages load ResetValue
//   d_i    : asynchronous input
//   q_o    : synchronised output (two cycles of latency)
// -----------------------------------------------------------------------------
module prim_flop_2sync #(
    parameter int               Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage1_q;
    logic [Width-1:0] stage2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage1_q <= ResetValue;
            stage2_q <= ResetValue;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
// Lock-qualified clock-enable generator. Waits for a stable PLL lock, then
// emits NumChannels independent one-cycle enable strobes at programmable
// divide ratios, plus a synchronous reset for downstream logic.
// Optional feature macro: CLK_EN_GEN_LOSS_COUNT_EN -- when defined, a
// saturating count of lock losses in RUN is kept; otherwise
// lock_loss_cnt_o is tied to zero.
// Ports:
//   clk_sys_i       : system clock
//   rst_sys_i       : synchronous active-high reset
//   pll_locked_i    : raw asynchronous PLL lock
//   div_i           : per-channel divide, channel i at [i*DivWidth +: DivWidth]
//   div_we_i        : per-channel write strobe for div_i
//   sync_i          : realign all channel counters to zero (RUN only)
//   clk_en_o        : per-channel one-cycle enable strobes
//   ready_o         : high in RUN
//   rst_out_o       : downstream reset, equals !ready_o
//   lock_loss_cnt_o : saturating lock-loss count
// -----------------------------------------------------------------------------
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int NumChannels      = 4,
    parameter int DivWidth         = 16,
    parameter int LockStableCycles = 1024,
    parameter int DefaultDiv       = 0
) (
    input  logic                            clk_sys_i,
    input  logic                            rst_sys_i,
    input  logic                            pll_locked_i,
    input  logic [NumChannels*DivWidth-1:0] div_i,
    input  logic [NumChannels-1:0]          div_we_i,
    input  logic                            sync_i,
    output logic [NumChannels-1:0]          clk_en_o,
    output logic                            ready_o,
    output logic                            rst_out_o,
    output logic [LossCntWidth-1:0]         lock_loss_cnt_o
);

    localparam int StableW = (LockStableCycles > 1) ? $clog2(LockStableCycles) : 1;
    localparam logic [StableW-1:0] StableLast = StableW'(LockStableCycles - 1);

    logic               lock_s;
    state_e             state_q;
    logic [StableW-1:0] stable_cnt_q;
    logic               ready_q;
    logic               sync_run;

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_lock_sync (
        .clk_i (clk_sys_i),
        .rst_i (rst_sys_i),
        .d_i   (pll_locked_i),
        .q_o   (lock_s)
    );

    // ready_q is registered alongside the state so it is exactly (state == RUN).
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q      <= WAIT_LOCK;
            stable_cnt_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q      <= STABILISE;
                        stable_cnt_q <= '0;
                    end
                end
                STABILISE: begin
                    if (!lock_s) begin
                        state_q      <= WAIT_LOCK;
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q == StableLast) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + StableW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= WAIT_LOCK;
                    stable_cnt_q <= '0;
                    ready_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_EN_GEN_LOSS_COUNT_EN
    logic [LossCntWidth-1:0] loss_cnt_q;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            loss_cnt_q <= '0;
        end else if (ready_q && !lock_s && (loss_cnt_q != LossCntMax)) begin
            loss_cnt_q <= loss_cnt_q + LossCntWidth'(1);
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`else
    assign lock_loss_cnt_o = '0;
`endif

    assign ready_o   = ready_q;
    assign rst_out_o = ~ready_q;
    assign sync_run  = sync_i & ready_q;

    for (genvar g = 0; g < NumChannels; g++) begin : g_chan
        clk_en_gen_chan #(
            .DivWidth   (DivWidth),
            .DefaultDiv (DefaultDiv)
        ) u_chan (
            .clk_i    (clk_sys_i),
            .rst_i    (rst_sys_i),
            .run_i    (ready_q),
            .sync_i   (sync_run),
            .div_we_i (div_we_i[g]),
            .div_i    (div_i[g*DivWidth +: DivWidth]),
            .clk_en_o (clk_en_o[g])
        );
    end

endmodule
